mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Shares one external memory bus (Wishbone-style, single outstanding cycle) between the IF stage (instruction fetch, read-only) and the MEM stage (load/store).
- Raises stall requests toward the pipeline controller (stallreq_from_if, stallreq_from_mem) until each requester is served.
- Handles pipeline flush and hung-bus timeout.

Parameters:
- ADDR_W, 32, address width for all ports
- DATA_W, 32, data width; SEL width is DATA_W/8
- TIMEOUT, 255, bus cycles without ack before abort; 0 disables the timeout

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- flush  in  1  pipeline flush; cancels IF result delivery
- if_req  in  1  IF fetch request, held until if_ack
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched instruction, valid with if_ack
- if_ack  out  1  one-cycle completion pulse to IF
- mem_req  in  1  MEM access request, held until mem_ack
- mem_we  in  1  1=store, 0=load
- mem_addr  in  ADDR_W  data address
- mem_sel  in  DATA_W/8  byte enables
- mem_wdata  in  DATA_W  store data
- mem_rdata  out  DATA_W  load data, valid with mem_ack
- mem_ack  out  1  one-cycle completion pulse to MEM
- bus_err  out  1  one-cycle pulse on timeout abort
- stallreq_from_if  out  1  IF waiting on bus
- stallreq_from_mem  out  1  MEM waiting on bus
- bus_cyc, bus_stb  out  1  bus cycle/strobe, always driven equal
- bus_we  out  1  bus write enable
- bus_addr  out  ADDR_W  bus address
- bus_sel  out  DATA_W/8  bus byte enables
- bus_wdata  out  DATA_W  bus write data
- bus_rdata  in  DATA_W  bus read data
- bus_ack  in  1  bus acknowledge

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; timeout counter 0; flush_pend 0.
- States: IDLE, BUS_MEM, BUS_IF, DONE.
- IDLE:
  - mem_req=1: latch MEM request fields onto bus, assert cyc/stb, go to BUS_MEM.
  - Else if_req=1: drive if_addr, we=0, sel all-ones, go to BUS_IF.
  - MEM has fixed priority over IF; a simultaneous request grants MEM.
- Bus outputs are registered and stable for the whole cycle; the first strobe appears the cycle after the request is sampled.
- BUS_MEM/BUS_IF, on bus_ack=1:
  - Deassert cyc/stb next edge.
  - Register bus_rdata into the matching rdata output and pulse the matching ack for one cycle.
  - Go to DONE.
- BUS_IF with flush seen at any point during the cycle (flush_pend set):
  - Bus cycle runs to completion; if_ack is suppressed and if_rdata is unchanged.
  - flush_pend clears on exit from the state.
- DONE: one idle cycle, no new arbitration, so the requester can drop req. Then go to IDLE.
- Minimum latency, request to ack: 2 cycles plus bus wait states.
- Timeout counter:
  - Increments each cycle in BUS_* with bus_ack=0.
  - On reaching TIMEOUT: drop cyc/stb, pulse bus_err, pulse the owner's ack with rdata=0, go to DONE.
  - Clears on entry to BUS_*.
- stallreq_from_mem = mem_req & ~mem_ack (combinational). stallreq_from_if = if_req & ~if_ack.
- flush in IDLE or DONE has no effect. flush asserted with if_req in IDLE still grants IF, with flush_pend set.
- A late bus_ack after a timeout abort (cyc=0) is ignored.
- rdata outputs hold their last value between acks.

Decomposition:
- Shared defines header: state encodings (IDLE/BUS_MEM/BUS_IF/DONE), WriteEnable/WriteDisable, Stop/NoStop, ZeroWord, default widths.
- One natural sub-module: bus_timeout_cnt (enable, clear, TIMEOUT compare → expired).
- The pipeline controller gains a stallreq_from_if input; that change is outside this block.

Test Plan:
- Fetch only: if_req=1, if_addr=0x00000100, slave acks after 3 wait cycles with 0x3C011234. Expect if_ack one-cycle pulse, if_rdata=0x3C011234, stallreq_from_if high until ack, bus_we=0, bus_sel=4'hF.
- Simultaneous: if_req and mem_req (store, addr 0x80, sel 4'b0011, wdata 0xDEADBEEF) together. Expect MEM served first with bus_we=1 and those fields; IF strobe starts only after DONE; if_ack follows mem_ack.
- Flush: flush pulses mid BUS_IF. Expect bus cycle completes, no if_ack, state returns to IDLE, next if_req served normally.
- Timeout: TIMEOUT=4, slave never acks a load. Expect cyc drops after 4 cycles, bus_err and mem_ack pulse, mem_rdata=0; a later stray bus_ack is ignored.
- Reset mid-cycle: rst=0 during BUS_MEM. Expect all outputs 0 immediately (async); after release, mem_req re-arbitrated from IDLE.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the IF/MEM memory bus arbiter.
package mem_bus_arbiter_pkg;

    localparam int unsigned DEF_ADDR_W  = 32;
    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_TIMEOUT = 255;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUS_MEM = 2'd1,
        BUS_IF  = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;
    localparam logic STOP          = 1'b1;
    localparam logic NO_STOP       = 1'b0;

    // True while a bus cycle is owned by one of the requesters.
    function automatic logic in_bus(input state_t s);
        return (s == BUS_MEM) || (s == BUS_IF);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_bus_timeout_cnt.sv
// Counts bus cycles without ack; flags expiry on the cycle the limit is reached.
module bus_timeout_cnt #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expired_c
);

    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // The current no-ack cycle is the TIMEOUT-th one; TIMEOUT of 0 never expires.
    assign expired_c = (TIMEOUT != 0) && en && (cnt == LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one single-outstanding Wishbone-style bus between IF fetches and MEM loads/stores.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_ack,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [ADDR_W-1:0]     mem_addr,
    input  logic [DATA_W/8-1:0]   mem_sel,
    input  logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W-1:0]     mem_rdata,
    output logic                  mem_ack,
    output logic                  bus_err,
    output logic                  stallreq_from_if,
    output logic                  stallreq_from_mem,
    output logic                  bus_cyc,
    output logic                  bus_stb,
    output logic                  bus_we,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [DATA_W/8-1:0]   bus_sel,
    output logic [DATA_W-1:0]     bus_wdata,
    input  logic [DATA_W-1:0]     bus_rdata,
    input  logic                  bus_ack
);

    state_t state;
    logic   cyc;
    logic   flush_pend;
    logic   tmo_en_c;
    logic   tmo_clr_c;
    logic   expired_c;

    assign bus_cyc = cyc;
    assign bus_stb = cyc;

    assign tmo_en_c  = in_bus(state) && !bus_ack;
    assign tmo_clr_c = !in_bus(state);

    bus_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .en        (tmo_en_c),
        .clr       (tmo_clr_c),
        .expired_c (expired_c)
    );

    assign stallreq_from_mem = (mem_req && !mem_ack) ? STOP : NO_STOP;
    assign stallreq_from_if  = (if_req && !if_ack) ? STOP : NO_STOP;

    // Arbitration FSM; every bus and response output is registered here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cyc        <= 1'b0;
            bus_we     <= WRITE_DISABLE;
            bus_addr   <= '0;
            bus_sel    <= '0;
            bus_wdata  <= '0;
            if_rdata   <= '0;
            if_ack     <= 1'b0;
            mem_rdata  <= '0;
            mem_ack    <= 1'b0;
            bus_err    <= 1'b0;
            flush_pend <= 1'b0;
        end else begin
            if_ack  <= 1'b0;
            mem_ack <= 1'b0;
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_req) begin
                        cyc       <= 1'b1;
                        bus_we    <= mem_we;
                        bus_addr  <= mem_addr;
                        bus_sel   <= mem_sel;
                        bus_wdata <= mem_wdata;
                        state     <= BUS_MEM;
                    end else if (if_req) begin
                        cyc        <= 1'b1;
                        bus_we     <= WRITE_DISABLE;
                        bus_addr   <= if_addr;
                        bus_sel    <= '1;
                        bus_wdata  <= '0;
                        flush_pend <= flush;
                        state      <= BUS_IF;
                    end
                end
                BUS_MEM: begin
                    if (bus_ack || expired_c) begin
                        cyc       <= 1'b0;
                        mem_ack   <= 1'b1;
                        mem_rdata <= bus_ack ? bus_rdata : '0;
                        bus_err   <= !bus_ack;
                        state     <= DONE;
                    end
                end
                BUS_IF: begin
                    if (bus_ack || expired_c) begin
                        cyc        <= 1'b0;
                        bus_err    <= !bus_ack;
                        flush_pend <= 1'b0;
                        state      <= DONE;
                        // A flushed fetch still finishes on the bus but is never delivered.
                        if (!(flush_pend || flush)) begin
                            if_ack   <= 1'b1;
                            if_rdata <= bus_ack ? bus_rdata : '0;
                        end
                    end else if (flush) begin
                        flush_pend <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
